// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, types and S-box tables for the PRESENT datapath
package present_pkg;

   localparam int KEY_SIZE_DEFAULT = 80;
   localparam int NUM_ROUNDS       = 32;

   typedef logic [5:0] round_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      PRECOMP,
      READY
   } state_t;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam logic [3:0] INV_SBOX [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

endpackage

// File: rtl/present_key_update.sv
// rtl/present_key_update.sv - one forward or inverse step of the PRESENT key schedule
module present_key_update
   import present_pkg::*;
#(
   parameter int KEY_SIZE = KEY_SIZE_DEFAULT
) (
   input  logic [KEY_SIZE-1:0] key_i,
   input  logic [4:0]          ctr_i,
   input  logic                dir_i,
   output logic [KEY_SIZE-1:0] key_o
);

   // Round-counter XOR position differs between the 80- and 128-bit schedules.
   localparam int XOR_LO = (KEY_SIZE == 128) ? 62 : 15;

   logic [KEY_SIZE-1:0] fwd_k;
   logic [KEY_SIZE-1:0] inv_x;
   logic [KEY_SIZE-1:0] inv_k;

   // Forward step: rotate, substitute top nibble(s), mix in the counter; inverse undoes it in reverse order.
   always_comb begin
      fwd_k = {key_i[KEY_SIZE-62:0], key_i[KEY_SIZE-1:KEY_SIZE-61]};
      fwd_k[KEY_SIZE-1 -: 4] = SBOX[fwd_k[KEY_SIZE-1 -: 4]];
      if (KEY_SIZE == 128) begin
         fwd_k[KEY_SIZE-5 -: 4] = SBOX[fwd_k[KEY_SIZE-5 -: 4]];
      end
      fwd_k[XOR_LO +: 5] = fwd_k[XOR_LO +: 5] ^ ctr_i;

      inv_x = key_i;
      inv_x[XOR_LO +: 5] = inv_x[XOR_LO +: 5] ^ ctr_i;
      inv_x[KEY_SIZE-1 -: 4] = INV_SBOX[inv_x[KEY_SIZE-1 -: 4]];
      if (KEY_SIZE == 128) begin
         inv_x[KEY_SIZE-5 -: 4] = INV_SBOX[inv_x[KEY_SIZE-5 -: 4]];
      end
      inv_k = {inv_x[60:0], inv_x[KEY_SIZE-1:61]};

      key_o = dir_i ? inv_k : fwd_k;
   end

endmodule

// File: rtl/present_key_schedule.sv
// rtl/present_key_schedule.sv - PRESENT round-key generator, forward or reverse order on request
module present_key_schedule #(
   parameter int KEY_SIZE   = present_pkg::KEY_SIZE_DEFAULT,
   parameter int NUM_ROUNDS = present_pkg::NUM_ROUNDS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [KEY_SIZE-1:0] orig_key,
   input  logic                mode,
   input  logic                next,
   output logic [63:0]         round_key,
   output logic [5:0]          round_idx,
   output logic                key_valid,
   output logic                last,
   output logic                busy
);

   import present_pkg::*;

   localparam round_idx_t LAST_IDX = round_idx_t'(NUM_ROUNDS);
   localparam round_idx_t PRE_END  = round_idx_t'(NUM_ROUNDS - 1);
   localparam round_idx_t ONE      = round_idx_t'(1);

   state_t              state_q, state_d;
   round_idx_t          cnt_q, cnt_d;
   logic [KEY_SIZE-1:0] key_q, key_d;
   logic                mode_q, mode_d;

   logic                upd_dir;
   logic [4:0]          upd_ctr;
   logic [KEY_SIZE-1:0] upd_key;

   logic [63:0]         round_key_q;
   round_idx_t          round_idx_q;
   logic                key_valid_q, last_q, busy_q;

   present_key_update #(.KEY_SIZE(KEY_SIZE)) u_update (
      .key_i (key_q),
      .ctr_i (upd_ctr),
      .dir_i (upd_dir),
      .key_o (upd_key)
   );

   // Next-state logic: load restarts from any state; next only advances in READY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      mode_d  = mode_q;
      upd_dir = 1'b0;
      upd_ctr = cnt_q[4:0];
      if (load) begin
         key_d   = orig_key;
         cnt_d   = ONE;
         mode_d  = mode;
         state_d = mode ? PRECOMP : READY;
      end else begin
         case (state_q)
            PRECOMP: begin
               key_d = upd_key;
               cnt_d = cnt_q + ONE;
               if (cnt_q == PRE_END) state_d = READY;
            end
            READY: begin
               if (next && !mode_q) begin
                  if (cnt_q == LAST_IDX) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     key_d = upd_key;
                     cnt_d = cnt_q + ONE;
                  end
               end else if (next && mode_q) begin
                  // Undo the step that produced this key, i.e. the one taken with cnt-1.
                  upd_dir = 1'b1;
                  upd_ctr = cnt_q[4:0] - 5'd1;
                  if (cnt_q == ONE) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     key_d = upd_key;
                     cnt_d = cnt_q - ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Schedule state and registered outputs, all derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         key_q       <= '0;
         mode_q      <= 1'b0;
         round_key_q <= '0;
         round_idx_q <= '0;
         key_valid_q <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         mode_q      <= mode_d;
         round_key_q <= (state_d == READY) ? key_d[KEY_SIZE-1 -: 64] : 64'd0;
         round_idx_q <= (state_d == READY) ? cnt_d : '0;
         key_valid_q <= (state_d == READY);
         last_q      <= (state_d == READY) &&
                        ((!mode_d && cnt_d == LAST_IDX) || (mode_d && cnt_d == ONE));
         busy_q      <= (state_d != IDLE);
      end
   end

   assign round_key = round_key_q;
   assign round_idx = round_idx_q;
   assign key_valid = key_valid_q;
   assign last      = last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_present_key_schedule.sv
// tb/tb_present_key_schedule.sv - self-checking bench for present_key_schedule, 80- and 128-bit builds
module tb_present_key_schedule;

   logic          clk, rst, load, mode, next;
   logic [79:0]   key80;
   logic [127:0]  key128;
   logic [63:0]   rk80, rk128;
   logic [5:0]    idx80, idx128;
   logic          kv80, kv128, last80, last128, busy80, busy128;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [63:0] m80 [33];
   logic [63:0] m128 [33];
   logic [63:0] got80 [32];
   logic [63:0] got128 [32];
   logic [63:0] fwd80 [32];
   logic [63:0] fwd128 [32];

   logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   typedef struct {
      logic [79:0] key;
      logic        m;
      int          idx;
      logic [63:0] want;
   } vec_t;
   vec_t tv [8];

   present_key_schedule #(.KEY_SIZE(80), .NUM_ROUNDS(32)) dut80 (
      .clk(clk), .rst(rst), .load(load), .orig_key(key80), .mode(mode), .next(next),
      .round_key(rk80), .round_idx(idx80), .key_valid(kv80), .last(last80), .busy(busy80)
   );

   present_key_schedule #(.KEY_SIZE(128), .NUM_ROUNDS(32)) dut128 (
      .clk(clk), .rst(rst), .load(load), .orig_key(key128), .mode(mode), .next(next),
      .round_key(rk128), .round_idx(idx128), .key_valid(kv128), .last(last128), .busy(busy128)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      total_cnt++;
      if (act === want) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the key register is a ks-bit number; one schedule step with counter i.
   function automatic logic [127:0] model_step(input logic [127:0] k, input int ks, input int i);
      logic [127:0] mask, r;
      logic [3:0]   n;
      mask = (ks == 128) ? {128{1'b1}} : ((128'd1 << 80) - 128'd1);
      r = ((k << 61) | (k >> (ks - 61))) & mask;
      n = 4'(r >> (ks - 4));
      r = r ^ (128'(n ^ sb[n]) << (ks - 4));
      if (ks == 128) begin
         n = 4'(r >> 120);
         r = r ^ (128'(n ^ sb[n]) << 120);
      end
      r = r ^ (128'(i) << ((ks == 128) ? 62 : 15));
      return r;
   endfunction

   task automatic fill_model(input logic [79:0] a, input logic [127:0] b);
      logic [127:0] ka, kb;
      ka = {48'd0, a};
      kb = b;
      for (int r = 1; r <= 32; r++) begin
         m80[r]  = 64'(ka >> 16);
         m128[r] = 64'(kb >> 64);
         ka = model_step(ka, 80, r);
         kb = model_step(kb, 128, r);
      end
   endtask

   task automatic do_load(input logic [79:0] a, input logic [127:0] b, input logic m);
      key80 = a; key128 = b; mode = m; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!kv80 && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   task automatic drain(input logic m, output int bad_idx, output int bad_last);
      int e;
      bad_idx = 0;
      bad_last = 0;
      for (int j = 0; j < 32; j++) begin
         got80[j]  = rk80;
         got128[j] = rk128;
         e = m ? 32 - j : j + 1;
         if (idx80 !== 6'(e) || idx128 !== 6'(e) || kv80 !== 1'b1 || kv128 !== 1'b1) bad_idx++;
         if (last80 !== (j == 31) || last128 !== (j == 31)) bad_last++;
         next = 1'b1;
         tick();
      end
      next = 1'b0;
   endtask

   task automatic run_full(input logic [79:0] a, input logic [127:0] b, input logic m);
      int cyc, bi, bl;
      fill_model(a, b);
      do_load(a, b, m);
      wait_valid(cyc);
      chk(m ? "latency_rev" : "latency_fwd", 128'(cyc), m ? 128'd32 : 128'd1);
      drain(m, bi, bl);
      chk("idx_sequence", 128'(bi), 128'd0);
      chk("last_only_at_end", 128'(bl), 128'd0);
      chk("valid_falls_after_last", {kv80, kv128, busy80, busy128}, 128'd0);
      for (int j = 0; j < 32; j++) begin
         chk("rk80_vs_model", got80[j], m ? m80[32 - j] : m80[j + 1]);
         chk("rk128_vs_model", got128[j], m ? m128[32 - j] : m128[j + 1]);
      end
   endtask

   task automatic both_ways(input logic [79:0] a, input logic [127:0] b);
      run_full(a, b, 1'b0);
      for (int j = 0; j < 32; j++) begin
         fwd80[j] = got80[j];
         fwd128[j] = got128[j];
      end
      run_full(a, b, 1'b1);
      for (int j = 0; j < 32; j++) begin
         chk("rev80_eq_fwd_reversed", got80[j], fwd80[31 - j]);
         chk("rev128_eq_fwd_reversed", got128[j], fwd128[31 - j]);
      end
      chk("rev80_k1_is_key_top", got80[31], a[79:16]);
      chk("rev128_k1_is_key_top", got128[31], b[127:64]);
   endtask

   initial begin
      logic [79:0]  a;
      logic [127:0] b;
      int cyc, steps;

      rst = 1'b0; load = 1'b0; mode = 1'b0; next = 1'b0;
      key80 = '0; key128 = '0;

      tv[0] = '{80'h0, 1'b0, 1, 64'h0000000000000000};
      tv[1] = '{80'h0, 1'b0, 2, 64'hc000000000000000};
      tv[2] = '{80'h0, 1'b0, 3, 64'h5000180000000001};
      tv[3] = '{80'h0, 1'b1, 1, 64'h0000000000000000};
      tv[4] = '{80'h0, 1'b1, 2, 64'hc000000000000000};
      tv[5] = '{80'h0, 1'b1, 3, 64'h5000180000000001};
      tv[6] = '{80'h0123456789abcdef0123, 1'b0, 1, 64'h0123456789abcdef};
      tv[7] = '{80'h0123456789abcdef0123, 1'b1, 1, 64'h0123456789abcdef};

      // Reset state
      repeat (2) tick();
      chk("reset_outputs80", {rk80, idx80, kv80, last80, busy80}, 128'd0);
      chk("reset_outputs128", {rk128, idx128, kv128, last128, busy128}, 128'd0);
      rst = 1'b1;
      tick();
      chk("after_release_idle", {rk80, idx80, kv80, last80, busy80}, 128'd0);

      // Known vectors: walk to the requested index and compare
      for (int v = 0; v < 8; v++) begin
         do_load(tv[v].key, 128'd0, tv[v].m);
         wait_valid(cyc);
         steps = 0;
         while (idx80 !== 6'(tv[v].idx) && steps < 40) begin
            next = 1'b1;
            tick();
            steps++;
         end
         next = 1'b0;
         chk("table_idx", 128'(idx80), 128'(tv[v].idx));
         chk("table_key", rk80, tv[v].want);
      end

      // Full schedules: zero key, then random keys, both orders
      both_ways(80'd0, 128'd0);
      for (int it = 0; it < 3; it++) begin
         a = 80'({$urandom(), $urandom(), $urandom()});
         b = {$urandom(), $urandom(), $urandom(), $urandom()};
         both_ways(a, b);
      end

      // next in IDLE does nothing
      next = 1'b1;
      repeat (3) tick();
      next = 1'b0;
      chk("next_in_idle", {kv80, idx80, busy80, kv128}, 128'd0);

      // Restart at idx 10 with a new key in reverse mode
      a = 80'({$urandom(), $urandom(), $urandom()});
      do_load(a, 128'd0, 1'b0);
      repeat (9) begin
         next = 1'b1;
         tick();
      end
      next = 1'b0;
      chk("restart_at_idx10", 128'(idx80), 128'd10);
      a = 80'({$urandom(), $urandom(), $urandom()});
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      fill_model(a, b);
      do_load(a, b, 1'b1);
      chk("restart_no_stale", {kv80, rk80, idx80}, 128'd0);
      chk("restart_busy", 128'(busy80), 128'd1);
      wait_valid(cyc);
      chk("restart_latency", 128'(cyc), 128'd32);
      chk("restart_k32", rk80, m80[32]);
      chk("restart_k32_128", rk128, m128[32]);

      // load and next together: load wins
      a = 80'({$urandom(), $urandom(), $urandom()});
      next = 1'b1;
      do_load(a, 128'd0, 1'b0);
      next = 1'b0;
      chk("load_beats_next_idx", 128'(idx80), 128'd1);
      chk("load_beats_next_key", rk80, a[79:16]);

      // next held through PRECOMP has no effect
      a = 80'({$urandom(), $urandom(), $urandom()});
      fill_model(a, 128'd0);
      do_load(a, 128'd0, 1'b1);
      next = 1'b1;
      wait_valid(cyc);
      next = 1'b0;
      chk("next_in_precomp_latency", 128'(cyc), 128'd32);
      chk("next_in_precomp_key", rk80, m80[32]);
      chk("next_in_precomp_idx", 128'(idx80), 128'd32);

      // Asynchronous reset mid-PRECOMP
      do_load(a, 128'd0, 1'b1);
      repeat (5) tick();
      #2 rst = 1'b0;
      #1 chk("rst_mid_precomp", {rk80, idx80, kv80, last80, busy80}, 128'd0);
      #2 rst = 1'b1;
      repeat (40) tick();
      chk("rst_precomp_stays_idle", {kv80, busy80, kv128, busy128}, 128'd0);

      // Asynchronous reset mid-READY
      do_load(a, 128'd0, 1'b0);
      repeat (4) begin
         next = 1'b1;
         tick();
      end
      next = 1'b0;
      #2 rst = 1'b0;
      #1 chk("rst_mid_ready", {rk80, idx80, kv80, last80, busy80}, 128'd0);
      chk("rst_mid_ready128", {rk128, idx128, kv128, last128, busy128}, 128'd0);
      #2 rst = 1'b1;
      next = 1'b1;
      repeat (5) tick();
      next = 1'b0;
      chk("rst_ready_stays_idle", {kv80, idx80, busy80}, 128'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/present_key_schedule.md
# present_key_schedule

Round-key generator for the PRESENT block cipher datapath. It sits directly upstream of the encryption and decryption round cores. It captures the user key once, then delivers one 64-bit round key per request, in forward order (K1..K32) for encryption or reverse order (K32..K1) for decryption. The consuming core no longer holds the full key register or recomputes the schedule itself.

## Interface
Parameters:
- KEY_SIZE, 80, user key width; legal values are 80 and 128
- NUM_ROUNDS, 32, number of round keys delivered

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-low reset
- load  in  1  capture orig_key and mode, then start the schedule
- orig_key  in  KEY_SIZE  user key, sampled only on load
- mode  in  1  0 = forward order (encrypt), 1 = reverse order (decrypt); sampled on load
- next  in  1  consumer has used round_key and requests the following one
- round_key  out  64  current round key, equal to key_reg[KEY_SIZE-1 -: 64]
- round_idx  out  6  index of round_key, 1..NUM_ROUNDS; 0 when idle
- key_valid  out  1  round_key/round_idx are valid
- last  out  1  current key is the final one: idx 32 in forward order, idx 1 in reverse order
- busy  out  1  high from load until the final key is consumed

## Operation
- Key register: key_reg[KEY_SIZE-1:0]. Round counter: cnt[5:0].
- Forward update with counter i:
  - 80-bit: rotate left 61; k[79:76] = S(k[79:76]); k[19:15] ^= i.
  - 128-bit: rotate left 61; S-box on k[127:124] and on k[123:120]; k[66:62] ^= i.
- Inverse update with counter i: undo the counter XOR, apply inverse S-box to the same nibble(s), rotate right 61. It is the exact inverse of the forward update.
- FSM states:
  - IDLE: outputs quiescent. load → key_reg = orig_key, cnt = 1. Go to READY if mode = 0, or PRECOMP if mode = 1.
  - PRECOMP: each cycle apply the forward update with cnt, then cnt++. After the update with cnt = 31, go to READY with cnt = 32.
  - READY: key_valid = 1, round_idx = cnt.
    - next in forward mode: if cnt = 32, go to IDLE; otherwise apply the forward update with cnt, then cnt++.
    - next in reverse mode: if cnt = 1, go to IDLE; otherwise apply the inverse update with cnt-1, then cnt--.
- Priority rules:
  - load wins over next in the same cycle.
  - load in any state restarts the schedule immediately and discards any in-flight schedule.
  - next is ignored outside READY.
- busy = (state != IDLE). last = READY && ((mode = 0 && cnt = 32) || (mode = 1 && cnt = 1)).

## Timing
- Reset values: round_key = 0, round_idx = 0, key_valid = 0, last = 0, busy = 0, key_reg = 0, state = IDLE. Reset takes effect asynchronously; release is synchronous to clk.
- Reset mid-schedule aborts to IDLE. No key is emitted afterwards until a new load.
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Forward latency: key_valid rises 1 cycle after the load edge, with K1.
- Reverse latency: key_valid rises 32 cycles after the load edge, with K32 (1 capture + 31 PRECOMP cycles).
- With next held high, a new key appears every cycle. 32 consecutive next pulses drain the schedule. key_valid falls on the cycle after next at last.
- Holding next high in PRECOMP has no effect.

## Structure
- Package present_pkg holds:
  - KEY_SIZE_DEFAULT and NUM_ROUNDS
  - SBOX[16] and INV_SBOX[16] constants
  - the state enum {IDLE, PRECOMP, READY}
  - the 6-bit round-index type
- The round cores import the same package, so S-box tables exist once.
- Sub-module present_key_update: purely combinational, parameterized by KEY_SIZE. Inputs are key, counter and dir. Output is the next key. It is instantiated once, and dir is selected by the FSM.
- Top level: FSM, key_reg, cnt and output registers only.

## Test plan
- Forward order, zero key: orig_key = 0, mode = 0, load, then next every cycle.
  - K1 = 0000000000000000, K2 = c000000000000000, K3 = 5000180000000001.
  - last is asserted only at idx 32; key_valid falls one cycle after the 32nd next.
- Reverse order, zero key: mode = 0 and mode = 1 runs on the same key.
  - key_valid rises exactly 32 cycles after load.
  - The reverse sequence equals the forward sequence reversed for all 32 keys; K1 = 0 appears with last = 1.
- Random 80-bit and 128-bit keys (two builds), both modes: forward list reversed == reverse list.
  - A reverse-mode K1 that equals orig_key[KEY_SIZE-1 -: 64] proves exact inversion.
- Restart and contention cases:
  - load asserted at idx 10 with a new key and mode = 1 → PRECOMP restarts and no stale key appears.
  - load and next in the same cycle → load wins.
  - next while key_valid = 0 → no state change.
- Reset behaviour: rst pulled low mid-PRECOMP and mid-READY, between clock edges.
  - All outputs go to 0 immediately.
  - After release, key_valid stays 0 until the next load.
